alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_pkg.sv | 82 ++++++++
 rtl/alu_issue_ctrl_cond_check.sv | 42 ++++
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_issue_pkg : shared constants, FSM state type and decode helpers for   |
// |                 the ALU issue controller.                                |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_issue_pkg;

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b0001;
  localparam logic [3:0] c_ALU_ADDS = 4'b0010;
  localparam logic [3:0] c_ALU_SUBS = 4'b0011;
  localparam logic [3:0] c_ALU_CMP  = 4'b0100;
  localparam logic [3:0] c_ALU_AND  = 4'b0111;
  localparam logic [3:0] c_ALU_ORR  = 4'b1000;
  localparam logic [3:0] c_ALU_EOR  = 4'b1001;
  localparam logic [3:0] c_ALU_MVN  = 4'b1010;

  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_EOR = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_ADD = 4'b0100;
  localparam logic [3:0] c_OP_CMP = 4'b1010;
  localparam logic [3:0] c_OP_ORR = 4'b1100;
  localparam logic [3:0] c_OP_MVN = 4'b1111;

  localparam logic [3:0] c_COND_EQ = 4'h0;
  localparam logic [3:0] c_COND_NE = 4'h1;
  localparam logic [3:0] c_COND_CS = 4'h2;
  localparam logic [3:0] c_COND_CC = 4'h3;
  localparam logic [3:0] c_COND_MI = 4'h4;
  localparam logic [3:0] c_COND_PL = 4'h5;
  localparam logic [3:0] c_COND_VS = 4'h6;
  localparam logic [3:0] c_COND_VC = 4'h7;
  localparam logic [3:0] c_COND_HI = 4'h8;
  localparam logic [3:0] c_COND_LS = 4'h9;
  localparam logic [3:0] c_COND_GE = 4'hA;
  localparam logic [3:0] c_COND_LT = 4'hB;
  localparam logic [3:0] c_COND_GT = 4'hC;
  localparam logic [3:0] c_COND_LE = 4'hD;
  localparam logic [3:0] c_COND_AL = 4'hE;
  localparam logic [3:0] c_COND_NV = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE   = 2'd0;
  localparam state_t c_ST_DECODE = 2'd1;
  localparam state_t c_ST_EXEC   = 2'd2;
  localparam state_t c_ST_WB     = 2'd3;

  typedef struct packed {
    logic       legal;
    logic [3:0] ctrl;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] opcode, input logic s);
    alu_dec_t d;
    d.legal = 1'b1;
    d.ctrl  = c_ALU_ADD;
    case (opcode)
      c_OP_AND: d.ctrl = c_ALU_AND;
      c_OP_EOR: d.ctrl = c_ALU_EOR;
      c_OP_ORR: d.ctrl = c_ALU_ORR;
      c_OP_SUB: d.ctrl = s ? c_ALU_SUBS : c_ALU_SUB;
      c_OP_ADD: d.ctrl = s ? c_ALU_ADDS : c_ALU_ADD;
      c_OP_CMP: d.ctrl = c_ALU_CMP;
      c_OP_MVN: d.ctrl = c_ALU_MVN;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // ARM rotated immediate: imm8 rotated right by twice the 4-bit field.
  function automatic logic [31:0] ror_imm(input logic [7:0] imm, input logic [3:0] rot);
    logic [63:0] w;
    w = {2{{24'd0, imm}}} >> {rot, 1'b0};
    return w[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_cond_check.sv
// +--------------------------------------------------------------------------+
// | cond_check : combinational ARM condition-field evaluation against NZCV.  |
// | Revision   : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module cond_check
  import alu_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      c_COND_EQ: pass = w_z;
      c_COND_NE: pass = !w_z;
      c_COND_CS: pass = w_c;
      c_COND_CC: pass = !w_c;
      c_COND_MI: pass = w_n;
      c_COND_PL: pass = !w_n;
      c_COND_VS: pass = w_v;
      c_COND_VC: pass = !w_v;
      c_COND_HI: pass = w_c && !w_z;
      c_COND_LS: pass = !w_c || w_z;
      c_COND_GE: pass = (w_n == w_v);
      c_COND_LT: pass = (w_n != w_v);
      c_COND_GT: pass = !w_z && (w_n == w_v);
      c_COND_LE: pass = w_z || (w_n != w_v);
      c_COND_AL: pass = 1'b1;
      default:   pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +--------------------------------------------------------------------------+
// | alu_issue_ctrl : issues ARM data-processing words to the ALU, handles     |
// |                  condition check, write-back and NZCV update.            |
// | Option         : ALU_ROT_IMM_EN enables rotated immediates.              |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_negative,
  output logic        wb_valid,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [3:0]  nzcv,
  output logic        illegal
);

  state_t      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [3:0]  r_alu_ctrl;
  logic [31:0] r_res;
  logic [3:0]  r_flags;
  logic        r_wb_valid;
  logic [3:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic [3:0]  r_nzcv;
  logic        r_illegal;

  logic        w_pass;
  logic        w_is_cmp;
  logic        w_is_mvn;
  logic        w_s;
  alu_dec_t    w_dec;
  logic [31:0] w_imm;
  logic [31:0] w_op_b;

  assign w_s      = r_instr[20];
  assign w_is_cmp = (r_instr[24:21] == c_OP_CMP);
  assign w_is_mvn = (r_instr[24:21] == c_OP_MVN);
  assign w_dec    = alu_decode(r_instr[24:21], w_s);

`ifdef ALU_ROT_IMM_EN
  assign w_imm = ror_imm(r_instr[7:0], r_instr[11:8]);
`else
  logic w_unused_rot;
  assign w_unused_rot = ^r_instr[11:8];
  assign w_imm        = {24'd0, r_instr[7:0]};
`endif

  assign w_op_b = r_instr[25] ? w_imm : rm_data;

  cond_check u_cond_check (
    .cond (r_instr[31:28]),
    .nzcv (r_nzcv),
    .pass (w_pass)
  );

  // Ready is forced low while reset is asserted, not just in the IDLE state.
  assign instr_ready   = (r_state == c_ST_IDLE) && rst_n;
  assign rn_addr       = r_instr[19:16];
  assign rm_addr       = r_instr[3:0];
  assign alu_operand_a = r_op_a;
  assign alu_operand_b = r_op_b;
  assign alu_control   = r_alu_ctrl;
  assign wb_valid      = r_wb_valid;
  assign wb_addr       = r_wb_addr;
  assign wb_data       = r_wb_data;
  assign nzcv          = r_nzcv;
  assign illegal       = r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_instr    <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_alu_ctrl <= '0;
      r_res      <= '0;
      r_flags    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_nzcv     <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= c_ST_DECODE;
          end
        end
        c_ST_DECODE: begin
          if (!w_dec.legal) begin
            r_illegal <= 1'b1;
            r_state   <= c_ST_IDLE;
          end else if (!w_pass) begin
            r_state <= c_ST_IDLE;
          end else begin
            // MVN inverts operand A inside the ALU, so A carries the operand-2 value.
            r_op_a     <= w_is_mvn ? w_op_b : rn_data;
            r_op_b     <= w_op_b;
            r_alu_ctrl <= w_dec.ctrl;
            r_state    <= c_ST_EXEC;
          end
        end
        c_ST_EXEC: begin
          r_res   <= alu_result;
          r_flags <= {alu_negative, alu_zero, alu_carry, alu_overflow};
          r_state <= c_ST_WB;
        end
        c_ST_WB: begin
          if (w_is_cmp) begin
            // Compare result encodes 1 = equal, 2 = less-than.
            r_nzcv <= {(r_res == 32'd2), (r_res == 32'd1), (r_res != 32'd2), 1'b0};
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_instr[15:12];
            r_wb_data  <= r_res;
            if (w_s) begin
              r_nzcv <= r_flags;
            end
          end
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_alu_issue_ctrl : scoreboard bench for alu_issue_ctrl with a register  |
// |                     file and ALU stub.                                   |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rn_addr, rm_addr;
  logic [31:0] rn_data, rm_data;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero, alu_carry, alu_overflow, alu_negative;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  nzcv;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .rn_addr       (rn_addr),
    .rm_addr       (rm_addr),
    .rn_data       (rn_data),
    .rm_data       (rm_data),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .alu_negative  (alu_negative),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .nzcv          (nzcv),
    .illegal       (illegal)
  );

  logic [31:0] regs [16];
  assign rn_data = regs[rn_addr];
  assign rm_data = regs[rm_addr];

  // ALU stub: ADDS/SUBS saturate on signed overflow; compare returns 1 eq, 2 lt, 0 gt.
  always_comb begin : alu_model
    logic [32:0] s;
    s            = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_control)
      4'b0000, 4'b0010: begin
        s            = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
        alu_result   = s[31:0];
        alu_carry    = s[32];
        alu_overflow = (alu_operand_a[31] == alu_operand_b[31]) && (s[31] != alu_operand_a[31]);
        if (alu_control == 4'b0010 && alu_overflow)
          alu_result = alu_operand_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      4'b0001, 4'b0011: begin
        s            = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
        alu_result   = s[31:0];
        alu_carry    = ~s[32];
        alu_overflow = (alu_operand_a[31] != alu_operand_b[31]) && (s[31] != alu_operand_a[31]);
        if (alu_control == 4'b0011 && alu_overflow)
          alu_result = alu_operand_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      4'b0100: alu_result = (alu_operand_a == alu_operand_b) ? 32'd1 :
                            ($signed(alu_operand_a) < $signed(alu_operand_b)) ? 32'd2 : 32'd0;
      4'b0111: alu_result = alu_operand_a & alu_operand_b;
      4'b1000: alu_result = alu_operand_a | alu_operand_b;
      4'b1001: alu_result = alu_operand_a ^ alu_operand_b;
      4'b1010: alu_result = ~alu_operand_a;
      default: alu_result = '0;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  typedef struct {
    bit          ill;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT write-back or illegal pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || illegal)) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: wb_valid=%0b illegal=%0b with empty scoreboard", wb_valid, illegal);
      end else begin
        e = sb.pop_front();
        check("event_is_illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (!e.ill) begin
          check("wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
          check("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] op,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cond, 2'b00, i, op, s, rn, rd, op2};
  endfunction

  task automatic issue(input logic [31:0] word);
    int w;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    instr       = word;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Cycles counted from the accepting edge until instr_ready returns; EXEC-cycle outputs sampled.
  task automatic run(input logic [31:0] word, output int cycles,
                     output logic [3:0] ctrl_x, output logic [31:0] opa_x);
    issue(word);
    cycles = 1;
    ctrl_x = alu_control;
    opa_x  = alu_operand_a;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 2) begin
        ctrl_x = alu_control;
        opa_x  = alu_operand_a;
      end
    end while (!instr_ready && cycles < 20);
  endtask

  initial begin
    int          cyc;
    logic [3:0]  ctl;
    logic [31:0] opa;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    regs[0] = 32'h7FFF_FFFF;
    regs[1] = 32'd1;
    regs[4] = 32'd5;

    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_nzcv", {28'd0, nzcv}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_op_a", alu_operand_a, 32'd0);
    check("rst_op_b", alu_operand_b, 32'd0);
    check("rst_ctrl", {28'd0, alu_control}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    // ADDS r2, r0, r1 : 0x7FFFFFFF + 1 saturates, V set
    sb.push_back('{ill: 1'b0, addr: 4'd2, data: 32'h7FFF_FFFF});
    run(dp(4'hE, 1'b0, 4'b0100, 1'b1, 4'd0, 4'd2, 12'd1), cyc, ctl, opa);
    check("adds_cycles", cyc, 32'd4);
    check("adds_ctrl", {28'd0, ctl}, 32'b0010);
    check("adds_nzcv", {28'd0, nzcv}, 32'b0001);

    // SUB r3, r4, r4 without S : result 0, flags untouched
    sb.push_back('{ill: 1'b0, addr: 4'd3, data: 32'd0});
    run(dp(4'hE, 1'b0, 4'b0010, 1'b0, 4'd4, 4'd3, 12'd4), cyc, ctl, opa);
    check("sub_cycles", cyc, 32'd4);
    check("sub_ctrl", {28'd0, ctl}, 32'b0001);
    check("sub_nzcv", {28'd0, nzcv}, 32'b0001);

    // CMP r0, r1 with equal operands
    regs[0] = 32'd3;
    regs[1] = 32'd3;
    run(dp(4'hE, 1'b0, 4'b1010, 1'b1, 4'd0, 4'd0, 12'd1), cyc, ctl, opa);
    check("cmp_cycles", cyc, 32'd4);
    check("cmp_ctrl", {28'd0, ctl}, 32'b0100);
    check("cmp_nzcv", {28'd0, nzcv}, 32'b0110);

    // ANDEQ r6, r0, r1 executes on the CMP flags
    sb.push_back('{ill: 1'b0, addr: 4'd6, data: 32'd3});
    run(dp(4'h0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd6, 12'd1), cyc, ctl, opa);
    check("andeq_cycles", cyc, 32'd4);
    check("andeq_nzcv", {28'd0, nzcv}, 32'b0110);

    // ANDNE r7, r0, r1 is skipped
    run(dp(4'h1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd7, 12'd1), cyc, ctl, opa);
    check("andne_cycles", cyc, 32'd2);
    check("andne_nzcv", {28'd0, nzcv}, 32'b0110);

    // MVN r5, #0x0F
    sb.push_back('{ill: 1'b0, addr: 4'd5, data: 32'hFFFF_FFF0});
    run(dp(4'hE, 1'b1, 4'b1111, 1'b0, 4'd0, 4'd5, 12'h00F), cyc, ctl, opa);
    check("mvn_cycles", cyc, 32'd4);
    check("mvn_ctrl", {28'd0, ctl}, 32'b1010);
    check("mvn_op_a", opa, 32'h0000_000F);

    // ADC is unsupported
    sb.push_back('{ill: 1'b1, addr: 4'd0, data: 32'd0});
    run(dp(4'hE, 1'b0, 4'b0101, 1'b1, 4'd0, 4'd8, 12'd1), cyc, ctl, opa);
    check("adc_cycles", cyc, 32'd2);
    check("adc_nzcv", {28'd0, nzcv}, 32'b0110);
    repeat (2) @(posedge clk);
    check("sb_drained_before_reset", sb.size(), 32'd0);

    // Reset while an ADDS sits in EXEC: aborted, flags cleared
    issue(dp(4'hE, 1'b0, 4'b0100, 1'b1, 4'd0, 4'd9, 12'd1));
    @(posedge clk);
    #1;
    check("abort_in_exec_ctrl", {28'd0, alu_control}, 32'b0010);
    rst_n = 1'b0;
    #1;
    check("abort_nzcv", {28'd0, nzcv}, 32'd0);
    check("abort_ready_low", {31'd0, instr_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_high", {31'd0, instr_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_nzcv_after", {28'd0, nzcv}, 32'd0);
    check("abort_wb_data", wb_data, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
